// File: rtl/alu_4bit.sv
// Two-state sequential 4-bit ALU: operands latched on an accepted start,
// result/error registered one cycle later together with a single Done pulse.
module alu_4bit (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic [3:0] A,
    input  logic [3:0] B,
    input  logic [1:0] opcode,
    output logic [7:0] Result,
    output logic       Done,
    output logic       Error
);

    typedef enum logic {
        IDLE = 1'b0,
        CALC = 1'b1
    } state_t;

    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_SUB = 2'b01;
    localparam logic [1:0] OP_MUL = 2'b10;
    localparam logic [1:0] OP_DIV = 2'b11;

    state_t     state_reg, state_next;
    logic [3:0] a_reg, a_next;
    logic [3:0] b_reg, b_next;
    logic [1:0] op_reg, op_next;
    logic [7:0] result_reg, result_next;
    logic       done_reg, done_next;
    logic       error_reg, error_next;

    logic [7:0] calc_result;
    logic       calc_error;
    logic [4:0] sum;
    logic [7:0] difference;
    logic [7:0] product;
    logic [3:0] divisor;
    logic [3:0] quotient;
    logic [3:0] remainder;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg  <= IDLE;
            a_reg      <= 4'h0;
            b_reg      <= 4'h0;
            op_reg     <= 2'b00;
            result_reg <= 8'h00;
            done_reg   <= 1'b0;
            error_reg  <= 1'b0;
        end else begin
            state_reg  <= state_next;
            a_reg      <= a_next;
            b_reg      <= b_next;
            op_reg     <= op_next;
            result_reg <= result_next;
            done_reg   <= done_next;
            error_reg  <= error_next;
        end
    end

    // Divisor is forced to 1 when B is zero so the divider never produces X;
    // the zero case is overridden below anyway.
    assign sum        = {1'b0, a_reg} + {1'b0, b_reg};
    assign difference = {4'h0, a_reg} - {4'h0, b_reg};
    assign product    = {4'h0, a_reg} * {4'h0, b_reg};
    assign divisor    = (b_reg == 4'h0) ? 4'h1 : b_reg;
    assign quotient   = a_reg / divisor;
    assign remainder  = a_reg % divisor;

    always_comb begin
        calc_result = 8'h00;
        calc_error  = 1'b0;
        case (op_reg)
            OP_ADD: calc_result = {3'b000, sum};
            OP_SUB: calc_result = difference;
            OP_MUL: calc_result = product;
            OP_DIV: begin
                if (b_reg == 4'h0) begin
                    calc_error = 1'b1;
                end else begin
                    calc_result = {remainder, quotient};
                end
            end
            default: calc_result = 8'h00;
        endcase
    end

    always_comb begin
        state_next  = state_reg;
        a_next      = a_reg;
        b_next      = b_reg;
        op_next     = op_reg;
        result_next = result_reg;
        error_next  = error_reg;
        done_next   = 1'b0;
        case (state_reg)
            IDLE: begin
                if (start) begin
                    a_next     = A;
                    b_next     = B;
                    op_next    = opcode;
                    state_next = CALC;
                end
            end
            CALC: begin
                result_next = calc_result;
                error_next  = calc_error;
                done_next   = 1'b1;
                state_next  = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    assign Result = result_reg;
    assign Done   = done_reg;
    assign Error  = error_reg;

endmodule

// File: tb/tb_alu_4bit.sv
// Scoreboard bench for alu_4bit: stimulus pushes expected results with a due
// cycle; a negedge monitor pops and checks on every Done pulse.
module tb_alu_4bit;

    logic       clk;
    logic       reset;
    logic       start;
    logic [3:0] A;
    logic [3:0] B;
    logic [1:0] opcode;
    logic [7:0] Result;
    logic       Done;
    logic       Error;

    typedef struct {
        logic [7:0] res;
        logic       err;
        int         due;
        int         id;
    } exp_t;

    exp_t exp_q[$];
    int   checks   = 0;
    int   failures = 0;
    int   cycle    = 0;
    int   txn_id   = 0;
    logic prev_done = 1'b0;

    alu_4bit dut (
        .clk    (clk),
        .reset  (reset),
        .start  (start),
        .A      (A),
        .B      (B),
        .opcode (opcode),
        .Result (Result),
        .Done   (Done),
        .Error  (Error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cycle <= cycle + 1;

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] required);
        checks++;
        if (actual !== required) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, actual, required);
        end
    endtask

    // Monitor: compare on each Done, flag overdue or unexpected completions.
    always @(negedge clk) begin
        if (!reset) begin
            if (Done) begin
                checks++;
                if (prev_done) begin
                    failures++;
                    $display("FAIL done_width actual=2+cycles required=1 cycle=%0d", cycle);
                end
                if (exp_q.size() == 0) begin
                    failures++;
                    $display("FAIL unexpected_done actual=Done=1 required=no_done cycle=%0d", cycle);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    checks += 2;
                    if (Result !== e.res || Error !== e.err || cycle != e.due) begin
                        failures++;
                        $display("FAIL txn%0d actual=res=%02h err=%0b cyc=%0d required=res=%02h err=%0b cyc=%0d",
                                 e.id, Result, Error, cycle, e.res, e.err, e.due);
                    end else begin
                        $display("txn%0d ok res=%02h err=%0b cyc=%0d", e.id, Result, Error, cycle);
                    end
                end
            end else if (exp_q.size() != 0 && cycle > exp_q[0].due) begin
                exp_t e;
                e = exp_q.pop_front();
                checks++;
                failures++;
                $display("FAIL txn%0d_timeout actual=no_done required=done_at_cycle_%0d", e.id, e.due);
            end
        end
        prev_done = Done;
    end

    // Called at a negedge with start about to be sampled on the next posedge.
    task automatic push_exp(input logic [7:0] res, input logic err);
        exp_t e;
        e.res = res;
        e.err = err;
        e.due = cycle + 2;
        e.id  = txn_id;
        txn_id++;
        exp_q.push_back(e);
    endtask

    task automatic issue(input logic [3:0] a, input logic [3:0] b, input logic [1:0] op,
                         input logic [7:0] res, input logic err);
        @(negedge clk);
        A = a; B = b; opcode = op; start = 1'b1;
        push_exp(res, err);
        @(negedge clk);
        start = 1'b0;
        A = ~a; B = ~b; opcode = ~op;
        @(negedge clk);
    endtask

    task automatic drain();
        for (int i = 0; i < 20 && exp_q.size() != 0; i++) @(negedge clk);
        check("queue_drained", exp_q.size(), 0);
    endtask

    initial begin
        reset = 1'b1; start = 1'b1; A = 4'hF; B = 4'hF; opcode = 2'b10;
        repeat (3) @(negedge clk);
        check("rst_result", Result, 8'h00);
        check("rst_done", Done, 0);
        check("rst_error", Error, 0);
        reset = 1'b0; start = 1'b0;

        issue(4'd5,  4'd3,  2'b00, 8'h08, 1'b0);
        issue(4'd10, 4'd4,  2'b01, 8'h06, 1'b0);
        issue(4'd3,  4'd5,  2'b01, 8'hFE, 1'b0);
        issue(4'd0,  4'd15, 2'b01, 8'hF1, 1'b0);
        issue(4'd5,  4'd3,  2'b10, 8'h0F, 1'b0);
        issue(4'd15, 4'd15, 2'b10, 8'hE1, 1'b0);
        issue(4'd10, 4'd2,  2'b11, 8'h05, 1'b0);
        issue(4'd11, 4'd3,  2'b11, 8'h23, 1'b0);
        issue(4'd7,  4'd9,  2'b11, 8'h70, 1'b0);
        issue(4'd8,  4'd0,  2'b11, 8'h00, 1'b1);
        issue(4'd15, 4'd15, 2'b00, 8'h1E, 1'b0);
        drain();

        // Results must hold between completions.
        repeat (3) @(negedge clk);
        check("hold_result", Result, 8'h1E);
        check("hold_error", Error, 0);

        // Back-to-back with start held high; CALC-cycle inputs are garbage.
        @(negedge clk);
        start = 1'b1;
        A = 4'd9;  B = 4'd7;  opcode = 2'b10; push_exp(8'h3F, 1'b0);
        @(negedge clk); A = 4'hF; B = 4'h0; opcode = 2'b11;
        @(negedge clk);
        A = 4'd12; B = 4'd12; opcode = 2'b01; push_exp(8'h00, 1'b0);
        @(negedge clk); A = 4'h1; B = 4'h1; opcode = 2'b10;
        @(negedge clk);
        A = 4'd4;  B = 4'd0;  opcode = 2'b11; push_exp(8'h00, 1'b1);
        @(negedge clk); A = 4'h3; B = 4'h3; opcode = 2'b00;
        @(negedge clk);
        A = 4'd1;  B = 4'd2;  opcode = 2'b00; push_exp(8'h03, 1'b0);
        @(negedge clk);
        start = 1'b0; A = 4'hE; B = 4'hE; opcode = 2'b10;
        drain();

        // Reset while in CALC: outputs clear at once and no Done follows.
        @(negedge clk);
        A = 4'd7; B = 4'd9; opcode = 2'b00; start = 1'b1;
        @(posedge clk);
        #2 reset = 1'b1;
        #1;
        check("rst_calc_result", Result, 8'h00);
        check("rst_calc_done", Done, 0);
        check("rst_calc_error", Error, 0);
        repeat (3) @(negedge clk);
        reset = 1'b0; start = 1'b0;
        repeat (4) @(negedge clk);
        check("rst_calc_no_done_result", Result, 8'h00);

        // First request after reset is accepted normally.
        issue(4'd2, 4'd3, 2'b10, 8'h06, 1'b0);
        drain();

        // Reset mid-cycle while Done is high.
        @(negedge clk);
        A = 4'd6; B = 4'd5; opcode = 2'b10; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        @(posedge clk);
        #1;
        check("pre_rst_done", Done, 1);
        check("pre_rst_result", Result, 8'h1E);
        #1 reset = 1'b1;
        #1;
        check("mid_rst_result", Result, 8'h00);
        check("mid_rst_done", Done, 0);
        check("mid_rst_error", Error, 0);
        repeat (2) @(negedge clk);
        reset = 1'b0;

        issue(4'd8, 4'd0, 2'b11, 8'h00, 1'b1);
        issue(4'd1, 4'd1, 2'b00, 8'h02, 1'b0);
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL global_timeout actual=running required=finished");
        $fatal(1, "timeout");
    end

endmodule
